// File: rtl/framebuf_arbiter.sv
// Single-port frame-buffer RAM arbiter: display reads take absolute priority, CPU stores go
// through a small FIFO that drains in free slots, and CPU loads issue only once that FIFO is empty.
module framebuf_arbiter #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IMG_W    = 392,
  parameter int unsigned IMG_H    = 392,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_active,
  input  logic [9:0]        vid_x,
  input  logic [9:0]        vid_y,
  output logic [DATA_W-1:0] vid_pixel,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [2:0]        wq_level,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_VOOB, TAG_RD} tag_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
  endfunction

  logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] pix_q, rdata_q;
  tag_t              tag_q, tag_d;
  logic              voob_q, voob_d;

  logic vid_inb, vid_slot, vid_oob, wr_slot, rd_slot, st_gnt, empty, full;

  assign vid_inb  = (32'(vid_x) < IMG_W) && (32'(vid_y) < IMG_H);
  assign vid_slot = rst_n & vid_active & vid_inb;
  assign vid_oob  = rst_n & vid_active & ~vid_inb;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(WQ_DEPTH));
  assign wr_slot  = rst_n & ~vid_slot & ~empty;
  assign rd_slot  = rst_n & ~vid_slot & empty & cpu_req & ~cpu_we;
  // Store acceptance depends only on queue space, never on who owns the RAM slot.
  assign st_gnt   = rst_n & cpu_req & cpu_we & ~full;

  assign cpu_gnt  = st_gnt | rd_slot;
  assign ram_wren = wr_slot;
  assign ram_data = wq_data_q[rd_ptr_q];
  assign wq_level = 3'(count_q);
  assign count_d  = count_q + CNT_W'(st_gnt) - CNT_W'(wr_slot);

  always_comb begin
    ram_address = addr_q;
    if (vid_slot)     ram_address = pix_addr(vid_x, vid_y);
    else if (wr_slot) ram_address = wq_addr_q[rd_ptr_q];
    else if (rd_slot) ram_address = cpu_addr;
  end

  // An out-of-bounds pixel may share its cycle with a load, so it gets its own flag
  // alongside the tag to keep both responses.
  always_comb begin
    tag_d = TAG_NONE;
    if (vid_slot)     tag_d = TAG_VID;
    else if (rd_slot) tag_d = TAG_RD;
    else if (vid_oob) tag_d = TAG_VOOB;
    voob_d = vid_oob & rd_slot;
  end

  assign vid_valid  = (tag_q == TAG_VID) | (tag_q == TAG_VOOB) | voob_q;
  assign vid_pixel  = (tag_q == TAG_VID) ? ram_q :
                      ((tag_q == TAG_VOOB) | voob_q) ? '0 : pix_q;
  assign cpu_rvalid = (tag_q == TAG_RD);
  assign cpu_rdata  = cpu_rvalid ? ram_q : rdata_q;

  // Stage boundary: slot decision -> in-flight tag steering the RAM read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= TAG_NONE;
      voob_q   <= 1'b0;
      pix_q    <= '0;
      rdata_q  <= '0;
    end else begin
      count_q <= count_d;
      tag_q   <= tag_d;
      voob_q  <= voob_d;
      if (st_gnt)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (wr_slot)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (vid_valid) pix_q    <= vid_pixel;
      if (cpu_rvalid) rdata_q <= cpu_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (st_gnt) begin
      wq_addr_q[wr_ptr_q] <= cpu_addr;
      wq_data_q[wr_ptr_q] <= cpu_wdata;
    end
    if (vid_slot | wr_slot | rd_slot) addr_q <= ram_address;
  end

endmodule

// File: tb/tb_framebuf_arbiter.sv
// Bench for framebuf_arbiter: behavioural RAM, shadow memory and per-stream scoreboards,
// a table of video fetches, and hand-written sequences for queueing, ordering and reset.
module tb_framebuf_arbiter;
  localparam int AW = 18;
  localparam int IW = 392;
  localparam int IH = 392;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0, vid_active = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [9:0]    vid_x = '0, vid_y = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    vid_pixel, cpu_rdata, ram_data, ram_q;
  logic          vid_valid, cpu_gnt, cpu_rvalid, ram_wren;
  logic [2:0]    wq_level;
  logic [AW-1:0] ram_address;

  framebuf_arbiter dut (
    .clk(clk), .rst_n(rst_n), .vid_active(vid_active), .vid_x(vid_x), .vid_y(vid_y),
    .vid_pixel(vid_pixel), .vid_valid(vid_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .wq_level(wq_level), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  logic [7:0] ram  [0:(1<<AW)-1];
  logic [7:0] refm [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_address] <= ram_data;
    ram_q <= ram[ram_address];
  end

  int checks = 0;
  int failures = 0;
  logic [7:0]  vq[$];
  logic [7:0]  rq[$];
  logic [25:0] wq[$];
  logic [25:0] wexp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vid_valid) begin
      if (vq.size() == 0) chk("vid_unexpected", 32'd1, 32'd0);
      else chk("vid_pixel", 32'(vid_pixel), 32'(vq.pop_front()));
    end
    if (cpu_rvalid) begin
      if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("cpu_rdata", 32'(cpu_rdata), 32'(rq.pop_front()));
    end
    if (ram_wren) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'(ram_address), 32'hFFFF_FFFF);
      else begin
        wexp = wq.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(wexp[25:8]));
        chk("wr_data", 32'(ram_data), 32'(wexp[7:0]));
      end
    end
  end

  task automatic drive(input logic rst, input logic va, input int x, input int y,
                       input logic req, input logic we, input int addr, input logic [7:0] wd);
    @(posedge clk); #1;
    rst_n = rst; vid_active = va; vid_x = 10'(x); vid_y = 10'(y);
    cpu_req = req; cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = wd;
    #1;
    if (rst) begin
      if (va) begin
        if (x < IW && y < IH) begin
          vq.push_back(refm[y*IW + x]);
          chk("vid_addr", 32'(ram_address), 32'(y*IW + x));
          chk("vid_nowren", 32'(ram_wren), 32'd0);
        end else vq.push_back(8'h00);
      end
      if (cpu_gnt && req && we) begin
        wq.push_back({AW'(addr), wd});
        refm[addr] = wd;
      end
      if (cpu_gnt && req && !we) rq.push_back(refm[addr]);
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 8'h00);
  endtask

  typedef struct { int x; int y; int exp_addr; logic inb; } vvec_t;
  vvec_t vt[8];

  initial begin
    vt[0] = '{5, 3, 1181, 1'b1};
    vt[1] = '{0, 0, 0, 1'b1};
    vt[2] = '{391, 391, 153663, 1'b1};
    vt[3] = '{391, 0, 391, 1'b1};
    vt[4] = '{0, 1, 392, 1'b1};
    vt[5] = '{392, 0, 0, 1'b0};
    vt[6] = '{0, 392, 0, 1'b0};
    vt[7] = '{1023, 1023, 0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (vt[i].inb) begin
        ram[vt[i].exp_addr]  = (i == 0) ? 8'hA5 : 8'(vt[i].exp_addr * 7 + 3);
        refm[vt[i].exp_addr] = (i == 0) ? 8'hA5 : 8'(vt[i].exp_addr * 7 + 3);
      end
    end

    // reset with requests asserted
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 50, 8'h11);
      chk("rst_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_wren", 32'(ram_wren), 32'd0);
      chk("rst_vvalid", 32'(vid_valid), 32'd0);
      chk("rst_level", 32'(wq_level), 32'd0);
    end

    // table of video fetches, in and out of bounds
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, vt[i].x, vt[i].y, 1'b0, 1'b0, 0, 8'h00);
      if (vt[i].inb) chk("tbl_addr", 32'(ram_address), 32'(vt[i].exp_addr));
      else chk("tbl_oob_wren", 32'(ram_wren), 32'd0);
    end
    idle(); idle();

    // out-of-bounds pixel lets a queued store through
    drive(1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 200, 8'h77);
    chk("oob_st_gnt", 32'(cpu_gnt), 32'd1);
    drive(1'b1, 1'b1, 392, 0, 1'b0, 1'b0, 0, 8'h00);
    chk("oob_wr_wren", 32'(ram_wren), 32'd1);
    chk("oob_wr_addr", 32'(ram_address), 32'd200);
    idle();
    chk("oob_vvalid", 32'(vid_valid), 32'd1);
    chk("oob_pix", 32'(vid_pixel), 32'd0);
    idle();

    // fill queue under active video, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 10 + i, 8'(8'h20 + i));
      chk("q_level", 32'(wq_level), 32'(i < 4 ? i : 4));
      chk("q_gnt", 32'(cpu_gnt), 32'(i < 4));
    end
    drive(1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 14, 8'h24);
    chk("q_full_gnt", 32'(cpu_gnt), 32'd0);
    chk("q_full_wren", 32'(ram_wren), 32'd0);
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 14, 8'h24);
    chk("q_pop_nopush", 32'(cpu_gnt), 32'd0);
    chk("q_pop0_addr", 32'(ram_address), 32'd10);
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 14, 8'h24);
    chk("q_push5_gnt", 32'(cpu_gnt), 32'd1);
    chk("q_pop1_addr", 32'(ram_address), 32'd11);
    for (int k = 0; k < 20 && wq_level != 0; k++) idle();
    chk("q_drained", 32'(wq_level), 32'd0);
    chk("q_wexp_empty", 32'(wq.size()), 32'd0);

    // read-after-write ordering
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 100, 8'h3C);
    chk("raw_st_gnt", 32'(cpu_gnt), 32'd1);
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 100, 8'h00);
    chk("raw_ld_wait", 32'(cpu_gnt), 32'd0);
    chk("raw_wren", 32'(ram_wren), 32'd1);
    chk("raw_wr_addr", 32'(ram_address), 32'd100);
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 100, 8'h00);
    chk("raw_ld_gnt", 32'(cpu_gnt), 32'd1);
    chk("raw_ld_nowren", 32'(ram_wren), 32'd0);
    chk("raw_ld_addr", 32'(ram_address), 32'd100);
    idle();
    chk("raw_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("raw_rdata", 32'(cpu_rdata), 32'h3C);

    // load stalled by video, then granted
    drive(1'b1, 1'b1, 5, 3, 1'b1, 1'b0, 1181, 8'h00);
    chk("ld_vid_stall", 32'(cpu_gnt), 32'd0);
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1181, 8'h00);
    chk("ld_gnt", 32'(cpu_gnt), 32'd1);
    idle();
    chk("ld_rdata", 32'(cpu_rdata), 32'hA5);
    idle();
    chk("ld_hold_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("ld_hold_rdata", 32'(cpu_rdata), 32'hA5);

    // reset discards queued stores
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 300 + i, 8'(8'h40 + i));
    chk("r6_level", 32'(wq_level), 32'd2);
    drive(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0, 8'h00);
    chk("r6_rst_wren", 32'(ram_wren), 32'd0);
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("r6_wren", 32'(ram_wren), 32'd0);
      chk("r6_level", 32'(wq_level), 32'd0);
    end

    idle(); idle();
    chk("sb_vid_empty", 32'(vq.size()), 32'd0);
    chk("sb_rd_empty", 32'(rq.size()), 32'd0);
    chk("sb_wr_empty", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
